// File: rtl/dr_alm_mult_arbiter.sv
// Round-robin arbiter sharing one DR-ALM multiplier among N_REQ requesters.
// Two-stage pipeline (operand reg -> product reg) with valid/ready response and full backpressure.
//
// LC operand layout: {k[LC_W-MULT_DW-2:0], f[MULT_DW:0]}, i.e. characteristic over truncated fraction.
// DR-ALM: s = fa + fb + 1 (LSB compensation); e = ka + kb + carry(s);
//         product = ({1, s mod 2^(MULT_DW+1)} * 2^e) >> (MULT_DW+1), truncated to A_BW+B_BW bits.
module dr_alm_mult_arbiter #(
   parameter int A_BW    = 32,
   parameter int B_BW    = 32,
   parameter int MULT_DW = 5,
   parameter int N_REQ   = 4,
   localparam int MAX_BW = (A_BW > B_BW) ? A_BW : B_BW,
   localparam int LC_W   = $clog2(MAX_BW) + MULT_DW + 2,
   localparam int ID_W   = $clog2(N_REQ),
   localparam int P_W    = A_BW + B_BW
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_REQ-1:0]        req_valid,
   output logic [N_REQ-1:0]        req_ready,
   input  logic [N_REQ*LC_W-1:0]   req_op_a,
   input  logic [N_REQ*LC_W-1:0]   req_op_b,
   input  logic [N_REQ-1:0]        req_zero,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [ID_W-1:0]         rsp_id,
   output logic [P_W-1:0]          rsp_product,
   output logic                    busy
);

   localparam int T_W   = MULT_DW + 1;
   localparam int K_W   = LC_W - T_W;
   localparam int E_W   = K_W + 1;
   localparam int ID_W1 = ID_W + 1;

   logic [LC_W-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
   logic            zero_q, zero_d;
   logic [ID_W-1:0] id_q, id_d;
   logic            s1_valid_q, s1_valid_d;
   logic [P_W-1:0]  prod_q, prod_d;
   logic [ID_W-1:0] rsp_id_q, rsp_id_d;
   logic            s2_valid_q, s2_valid_d;
   logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;

   logic            advance2, s1_free, accept, found;
   logic [N_REQ-1:0] grant;
   logic [ID_W-1:0] gnt_id, cand;
   logic [ID_W1-1:0] cand_sum;

   logic [K_W-1:0]  k_a, k_b;
   logic [T_W-1:0]  f_a, f_b;
   logic [T_W:0]    f_sum;
   logic [E_W-1:0]  exp_v;
   logic [P_W-1:0]  mant_ext, prod_raw;

   assign advance2 = s1_valid_q & (~s2_valid_q | rsp_ready);
   assign s1_free  = ~s1_valid_q | advance2;

   // Search upward from rr_ptr with wrap; sum is one bit wider so non-power-of-two N_REQ wraps correctly.
   always_comb begin
      grant    = '0;
      gnt_id   = '0;
      found    = 1'b0;
      cand_sum = '0;
      cand     = '0;
      for (int j = 0; j < N_REQ; j++) begin
         cand_sum = {1'b0, rr_ptr_q} + ID_W1'(j);
         if (cand_sum >= ID_W1'(N_REQ)) cand_sum = cand_sum - ID_W1'(N_REQ);
         cand = cand_sum[ID_W-1:0];
         if (!found && req_valid[cand]) begin
            found       = 1'b1;
            grant[cand] = 1'b1;
            gnt_id      = cand;
         end
      end
   end

   assign req_ready = (s1_free & ~rst) ? grant : '0;
   assign accept    = |req_ready;

   assign k_a      = op_a_q[LC_W-1 -: K_W];
   assign k_b      = op_b_q[LC_W-1 -: K_W];
   assign f_a      = op_a_q[T_W-1:0];
   assign f_b      = op_b_q[T_W-1:0];
   assign f_sum    = {1'b0, f_a} + {1'b0, f_b} + {{T_W{1'b0}}, 1'b1};
   assign exp_v    = {1'b0, k_a} + {1'b0, k_b} + {{K_W{1'b0}}, f_sum[T_W]};
   assign mant_ext = {{(P_W-T_W-1){1'b0}}, 1'b1, f_sum[T_W-1:0]};

   always_comb begin
      if (exp_v >= E_W'(T_W)) prod_raw = mant_ext << (exp_v - E_W'(T_W));
      else                    prod_raw = mant_ext >> (E_W'(T_W) - exp_v);
   end

   always_comb begin
      op_a_d     = op_a_q;
      op_b_d     = op_b_q;
      zero_d     = zero_q;
      id_d       = id_q;
      prod_d     = prod_q;
      rsp_id_d   = rsp_id_q;
      s1_valid_d = s1_valid_q;
      s2_valid_d = s2_valid_q;
      rr_ptr_d   = rr_ptr_q;
      if (advance2) begin
         prod_d     = zero_q ? '0 : prod_raw;
         rsp_id_d   = id_q;
         s2_valid_d = 1'b1;
         s1_valid_d = 1'b0;
      end else if (s2_valid_q && rsp_ready) begin
         s2_valid_d = 1'b0;
      end
      if (accept) begin
         op_a_d     = req_op_a[gnt_id*LC_W +: LC_W];
         op_b_d     = req_op_b[gnt_id*LC_W +: LC_W];
         zero_d     = req_zero[gnt_id];
         id_d       = gnt_id;
         s1_valid_d = 1'b1;
         rr_ptr_d   = (gnt_id == ID_W'(N_REQ-1)) ? '0 : gnt_id + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
         rr_ptr_q   <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s2_valid_q <= s2_valid_d;
         rr_ptr_q   <= rr_ptr_d;
      end
   end

   // Payload registers carry no reset; their valid bits gate every use.
   always_ff @(posedge clk) begin
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      zero_q   <= zero_d;
      id_q     <= id_d;
      prod_q   <= prod_d;
      rsp_id_q <= rsp_id_d;
   end

   assign rsp_valid   = s2_valid_q & ~rst;
   assign rsp_id      = rsp_id_q;
   assign rsp_product = prod_q;
   assign busy        = s1_valid_q | s2_valid_q;

endmodule

// File: tb/tb_dr_alm_mult_arbiter.sv
// Scoreboard bench for dr_alm_mult_arbiter: driver pushes expected products on accept,
// an independent monitor pops and compares on every response handshake.
module tb_dr_alm_mult_arbiter;

   localparam int A_BW = 32, B_BW = 32, MULT_DW = 5, N_REQ = 4;
   localparam int LC_W = 12, ID_W = 2, P_W = 64, T_W = MULT_DW + 1;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [N_REQ-1:0]      req_valid, req_ready, req_zero;
   logic [N_REQ*LC_W-1:0] req_op_a, req_op_b;
   logic                  rsp_valid, rsp_ready, busy;
   logic [ID_W-1:0]       rsp_id;
   logic [P_W-1:0]        rsp_product;

   dr_alm_mult_arbiter #(.A_BW(A_BW), .B_BW(B_BW), .MULT_DW(MULT_DW), .N_REQ(N_REQ)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_op_a(req_op_a), .req_op_b(req_op_b), .req_zero(req_zero),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_product(rsp_product), .busy(busy));

   always #5 clk = ~clk;

   typedef struct { int id; logic [P_W-1:0] prod; } exp_t;
   exp_t sb[$];
   int   grant_log[$];

   int n_checks = 0, n_fail = 0;
   int pushes = 0, pops = 0, occ = 0, ptr = 0, acc_cnt = 0;
   int mode = 0;  // 0: drop valid after accept, 1: new data keep valid, 2: random
   logic [N_REQ-1:0] vld;
   logic [LC_W-1:0]  opa [N_REQ];
   logic [LC_W-1:0]  opb [N_REQ];
   logic [N_REQ-1:0] zf;
   logic last_rsp_valid, last_busy;

   function automatic void chk(string name, logic [P_W-1:0] got, logic [P_W-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
      end
   endfunction

   // Reference DR-ALM: log-domain add with LSB compensation, then antilog by shifting.
   function automatic logic [P_W-1:0] ref_mult(logic [LC_W-1:0] a, logic [LC_W-1:0] b, logic z);
      int ka, kb, fa, fb, s, e;
      logic [255:0] big;
      if (z) return '0;
      ka = int'(a) / (1 << T_W);  fa = int'(a) % (1 << T_W);
      kb = int'(b) / (1 << T_W);  fb = int'(b) % (1 << T_W);
      s = fa + fb + 1;
      e = ka + kb;
      if (s >= (1 << T_W)) begin s -= (1 << T_W); e += 1; end
      big = 256'((1 << T_W) + s) << e;
      big = big >> T_W;
      return big[P_W-1:0];
   endfunction

   function automatic logic [LC_W-1:0] rand_op();
      logic [LC_W-1:0] v;
      v = LC_W'($urandom);
      if ($urandom_range(0, 7) != 0) v[LC_W-1] = 1'b0;  // mostly k within 0..31
      return v;
   endfunction

   task automatic new_data(int i);
      opa[i] = rand_op();
      opb[i] = rand_op();
      zf[i]  = (mode == 2) ? ($urandom_range(0, 9) == 0) : 1'b0;
   endtask

   task automatic drive();
      req_valid = vld;
      req_zero  = zf;
      for (int i = 0; i < N_REQ; i++) begin
         req_op_a[i*LC_W +: LC_W] = opa[i];
         req_op_b[i*LC_W +: LC_W] = opb[i];
      end
   endtask

   // One clock: drive, check the handshake side at negedge, advance to posedge+1.
   task automatic step();
      logic [N_REQ-1:0] exp_rdy;
      int gid, idx;
      exp_t e;
      drive();
      @(negedge clk);
      exp_rdy = '0;
      gid = -1;
      if (!rst && (occ < 2 || rsp_ready)) begin
         for (int j = 0; j < N_REQ; j++) begin
            idx = (ptr + j) % N_REQ;
            if (vld[idx]) begin gid = idx; break; end
         end
      end
      if (gid >= 0) exp_rdy[gid] = 1'b1;
      chk("req_ready", P_W'(req_ready), P_W'(exp_rdy));
      if (!rst) chk("busy", P_W'(busy), P_W'(occ != 0));
      last_rsp_valid = rsp_valid;
      last_busy      = busy;
      if (rst) begin
         sb.delete();
         pushes = pops;
         ptr    = 0;
      end else if (gid >= 0) begin
         e.id   = gid;
         e.prod = ref_mult(opa[gid], opb[gid], zf[gid]);
         sb.push_back(e);
         grant_log.push_back(gid);
         pushes++;
         acc_cnt++;
         ptr = (gid + 1) % N_REQ;
         if (mode == 0) vld[gid] = 1'b0;
         else if (mode == 1) new_data(gid);
         else if ($urandom_range(0, 1) == 0) vld[gid] = 1'b0;
         else new_data(gid);
      end
      @(posedge clk);
      #1;
      occ = pushes - pops;
      if (mode == 2) begin
         rsp_ready = ($urandom_range(0, 9) < 7);
         for (int i = 0; i < N_REQ; i++)
            if (!vld[i] && $urandom_range(0, 9) < 4) begin vld[i] = 1'b1; new_data(i); end
      end
   endtask

   task automatic drain();
      int n;
      mode = 0; vld = '0; rsp_ready = 1'b1;
      n = 0;
      while (pushes != pops && n < 20) begin step(); n++; end
      chk("drain_timeout", P_W'(pushes - pops), P_W'(0));
      step();
   endtask

   task automatic do_reset();
      rst = 1'b1; step(); step();
      rst = 1'b0;
   endtask

   // Monitor: pops the scoreboard on each response handshake and checks stall stability.
   logic            stall = 1'b0;
   logic [ID_W-1:0] h_id;
   logic [P_W-1:0]  h_prod;
   always @(negedge clk) begin
      exp_t e;
      if (rst) stall <= 1'b0;
      else begin
         if (stall) begin
            chk("hold_valid", P_W'(rsp_valid), P_W'(1));
            chk("hold_id", P_W'(rsp_id), P_W'(h_id));
            chk("hold_product", rsp_product, h_prod);
         end
         if (rsp_valid && sb.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL rsp_unexpected got id=%0d prod=%0h exp=no response at %0t", rsp_id, rsp_product, $time);
            if (rsp_ready) pops++;
            stall <= 1'b0;
         end else if (rsp_valid && rsp_ready) begin
            e = sb.pop_front();
            chk("rsp_id", P_W'(rsp_id), P_W'(e.id));
            chk("rsp_product", rsp_product, e.prod);
            pops++;
            stall <= 1'b0;
         end else if (rsp_valid) begin
            stall  <= 1'b1;
            h_id   <= rsp_id;
            h_prod <= rsp_product;
         end else stall <= 1'b0;
      end
   end

   initial begin
      int a0;
      rst = 1'b1; rsp_ready = 1'b0; vld = '1; zf = '0;
      for (int i = 0; i < N_REQ; i++) new_data(i);
      step(); step(); step();
      rst = 1'b0; vld = '0;
      step();
      chk("reset_rsp_valid", P_W'(last_rsp_valid), P_W'(0));
      chk("reset_busy", P_W'(last_busy), P_W'(0));

      // single request from requester 2, latency 2
      mode = 0; rsp_ready = 1'b1;
      new_data(2); vld[2] = 1'b1;
      step();
      step(); chk("lat_cycle1_valid", P_W'(last_rsp_valid), P_W'(0));
      step(); chk("lat_cycle2_valid", P_W'(last_rsp_valid), P_W'(1));
      drain();

      // fairness: all requesters, no idle response cycles
      do_reset();
      mode = 1; rsp_ready = 1'b1; vld = '1; grant_log.delete();
      for (int i = 0; i < N_REQ; i++) new_data(i);
      for (int k = 0; k < 8; k++) begin
         step();
         if (k >= 2) chk("fair_no_bubble", P_W'(last_rsp_valid), P_W'(1));
      end
      step(); chk("fair_no_bubble", P_W'(last_rsp_valid), P_W'(1));
      for (int k = 0; k < 8; k++) chk("fair_order", P_W'(grant_log[k]), P_W'(k % N_REQ));
      drain();

      // backpressure
      mode = 1; rsp_ready = 1'b0; vld = '1;
      a0 = acc_cnt;
      for (int k = 0; k < 6; k++) step();
      chk("bp_accepts", P_W'(acc_cnt - a0), P_W'(2));
      a0 = acc_cnt;
      rsp_ready = 1'b1; step();
      rsp_ready = 1'b0;
      for (int k = 0; k < 4; k++) step();
      chk("bp_one_more", P_W'(acc_cnt - a0), P_W'(1));
      drain();

      // zero override on requester 1
      mode = 0; vld = '0;
      opa[1] = 12'h2A5; opb[1] = 12'h1C3; zf[1] = 1'b1; vld[1] = 1'b1;
      step(); zf[1] = 1'b0;
      drain();

      // pointer wrap: 3 alone, then 0 and 3 together
      grant_log.delete();
      new_data(3); vld[3] = 1'b1; step();
      new_data(0); new_data(3); vld[0] = 1'b1; vld[3] = 1'b1;
      step(); step();
      chk("ptr_first", P_W'(grant_log[0]), P_W'(3));
      chk("ptr_wrap_to0", P_W'(grant_log[1]), P_W'(0));
      chk("ptr_then3", P_W'(grant_log[2]), P_W'(3));
      drain();

      // reset with both stages full
      mode = 1; rsp_ready = 1'b0; vld = '1;
      for (int k = 0; k < 3; k++) step();
      rst = 1'b1; step();
      rst = 1'b0; vld = '0; mode = 0;
      step();
      chk("rst_mid_rsp_valid", P_W'(last_rsp_valid), P_W'(0));
      chk("rst_mid_busy", P_W'(last_busy), P_W'(0));
      grant_log.delete();
      rsp_ready = 1'b1; vld = '1;
      for (int i = 0; i < N_REQ; i++) new_data(i);
      step();
      chk("rst_first_grant", P_W'(grant_log[0]), P_W'(0));
      drain();

      // random traffic
      mode = 2; vld = '0;
      for (int k = 0; k < 400; k++) step();
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/dr_alm_mult_arbiter.md
Name: dr_alm_mult_arbiter

Overview:
- Shares one DR-ALM multiplication unit among N_REQ requesters, e.g. PE columns or a weight-stationary sequencer.
- Requesters present log-converted operand pairs (LC format); the block round-robin arbitrates, registers the winner, drives the shared multiplier and registers the product.
- Each product is returned with the winning requester ID through a valid/ready response port with full backpressure.
- Sits between the log converters and the accumulators of the APTPU datapath.

Parameters:
- A_BW, 32, operand A bit width (product width A_BW+B_BW).
- B_BW, 32, operand B bit width.
- MULT_DW, 5, DR-ALM truncation width; truncation_width = MULT_DW+1.
- N_REQ, 4, number of requesters (>=2).
- LC_W, derived, $clog2(max(A_BW,B_BW))+MULT_DW+2 = 12 at defaults; LC operand width.
- ID_W, derived, $clog2(N_REQ) = 2 at defaults.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  N_REQ  per-requester operand-pair valid.
- req_ready  out  N_REQ  per-requester accept; at most one bit high per cycle.
- req_op_a  in  N_REQ*LC_W  LC operand A; requester i uses bits [i*LC_W +: LC_W].
- req_op_b  in  N_REQ*LC_W  LC operand B, same packing.
- req_zero  in  N_REQ  requester i flags that an original operand was zero.
- rsp_valid  out  1  product valid.
- rsp_ready  in  1  consumer accept.
- rsp_id  out  ID_W  requester index of the product.
- rsp_product  out  A_BW+B_BW  approximate product.
- busy  out  1  high while either pipeline stage holds data.

Behaviour:
- Pipeline stages:
  - S1 is the operand register: op_a, op_b, zero, id, s1_valid.
  - The multiplier is combinational from S1.
  - S2 is the result register: product, id, s2_valid.
- Advance rules:
  - advance2 = s1_valid & (~s2_valid | rsp_ready).
  - s1_free = ~s1_valid | advance2.
- Arbitration:
  - Round-robin over req_valid, starting at pointer rr_ptr and searching upward with wrap.
  - grant is one-hot; req_ready = grant when s1_free, else all zero.
  - req_ready depends only on req_valid and state, never on its own output.
- Accept: when req_valid[i] & req_ready[i], S1 loads requester i's operands, zero flag and id, and s1_valid <= 1; rr_ptr <= (i+1) mod N_REQ.
- Grant hold: with no accept, rr_ptr holds. A requester must keep valid and data stable until accepted.
- S2 load:
  - On advance2, S2 loads the multiplier output, forced to all-zero if the S1 zero flag is set, plus the S1 id; s2_valid <= 1.
  - If S1 is not refilled in the same cycle, s1_valid <= 0.
- Response: rsp_valid = s2_valid. On rsp_valid & rsp_ready without advance2, s2_valid <= 0. rsp_product and rsp_id hold stable while rsp_valid & ~rsp_ready.
- Latency and throughput:
  - Accept in cycle t gives rsp_valid in cycle t+2 if unstalled.
  - One product per cycle sustained when rsp_ready is held high.
- Simultaneous events: accept, S1->S2 transfer and response pop may all occur in one cycle; no bubble is inserted.
- Full condition: both stages valid and rsp_ready low, so req_ready is all zero and the pipeline holds.
- Arithmetic:
  - The product equals the standalone DR-ALM unit (adder-compensation then antilog) for the same LC operands; the block adds no rounding.
  - Zero flag overrides the product to 0.
- busy = s1_valid | s2_valid.
- Reset, including mid-operation:
  - s1_valid = s2_valid = 0, rr_ptr = 0, rsp_valid = 0, req_ready = 0 in the reset cycle, busy = 0.
  - In-flight data is discarded; data registers need no reset.
- N_REQ not a power of two: rr_ptr wraps at N_REQ-1 to 0.

Test Plan:
- Single request: req_valid=4'b0100 with operands P, Q at cycle 0 -> req_ready=4'b0100 at cycle 0; rsp_valid at cycle 2 with rsp_id=2 and rsp_product equal to the standalone multiplier's output for P, Q.
- Fairness: all four req_valid held high for 8 cycles, rsp_ready=1 -> grants in order 0,1,2,3,0,1,2,3; rsp_id follows the same order from cycle 2, with no idle cycles.
- Backpressure: rsp_ready=0 with continuous requests -> exactly 2 accepts, then req_ready=0. rsp_product and rsp_id stay stable. After rsp_ready=1 for one cycle, exactly one more accept occurs.
- Zero override: req_zero[1]=1 with nonzero LC operands -> rsp_product=0, rsp_id=1.
- Pointer hold: requester 3 only, then requesters 0 and 3 together -> grant goes to 0 (rr_ptr wrapped to 0), then to 3.
- Reset mid-flight: assert rst with both stages full -> next cycle rsp_valid=0 and busy=0. After release, the first grant goes to requester 0 and no stale product is emitted.
